jtdd_mcu_com: RTL and testbench

- Shared-RAM and handshake block between the main 6809 and the HD63701 MCU in the DD/DD2 core.
- Holds the 512-byte communication RAM. Main side decodes it as com_cs; its read data returns to the main CPU as mcu_ram.
- Arbitrates that RAM by a halt/bus-available handshake.
- Latches the main-to-MCU NMI request and stretches the MCU-to-main IRQ into a level the main interrupt edge detector can sample.

---
 rtl/jtdd_pkg.sv | 17 +
 rtl/jtdd_mcu_com_if.sv | 30 +++
 rtl/jtframe_ram.sv | 18 +
 rtl/jtdd_mcu_com.sv | 109 ++++++++++
 tb/tb_jtdd_mcu_com.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/jtdd_pkg.sv
// rtl/jtdd_pkg.sv - shared types and constants for the DD main/MCU communication block
package jtdd_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HREQ   = 2'd1,
        HALTED = 2'd2,
        HREL   = 2'd3
    } halt_st_t;

    localparam int DEF_AW      = 9;
    localparam int DEF_IRQ_LEN = 4;
    localparam int DEF_HALT_TO = 64;

    localparam logic [7:0] IDLE_RD = 8'hFF;

endpackage

// File: rtl/jtdd_mcu_com_if.sv
// rtl/jtdd_mcu_com_if.sv - main and MCU access ports of the shared communication RAM
interface jtdd_mcu_com_if
    import jtdd_pkg::*;
#(
    parameter int AW = DEF_AW
);
    logic          main_cs;
    logic          main_rnw;
    logic [AW-1:0] main_addr;
    logic [7:0]    main_dout;
    logic [7:0]    main_din;

    logic          mcu_ram_cs;
    logic          mcu_wr;
    logic [AW-1:0] mcu_addr;
    logic [7:0]    mcu_dout;
    logic [7:0]    mcu_din;

    modport master (
        output main_cs, main_rnw, main_addr, main_dout,
        output mcu_ram_cs, mcu_wr, mcu_addr, mcu_dout,
        input  main_din, mcu_din
    );

    modport slave (
        input  main_cs, main_rnw, main_addr, main_dout,
        input  mcu_ram_cs, mcu_wr, mcu_addr, mcu_dout,
        output main_din, mcu_din
    );
endinterface

// File: rtl/jtframe_ram.sv
// rtl/jtframe_ram.sv - single-port synchronous RAM with registered read
module jtframe_ram #(
    parameter int DW = 8,
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] data,
    input  logic          we,
    output logic [DW-1:0] q
);
    logic [DW-1:0] mem [0:(2**AW)-1];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= data;
        q <= mem[addr];
    end
endmodule

// File: rtl/jtdd_mcu_com.sv
// rtl/jtdd_mcu_com.sv - shared RAM, halt handshake, NMI latch and IRQ stretch between main 6809 and MCU
module jtdd_mcu_com
    import jtdd_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int IRQ_LEN = DEF_IRQ_LEN,
    parameter int HALT_TO = DEF_HALT_TO
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           cpu_cen,
    jtdd_mcu_com_if.slave  bus,
    input  logic           mcu_halt,
    input  logic           mcu_nmi_set,
    output logic           mcu_ban,
    output logic           mcu_haltn,
    input  logic           mcu_bs,
    output logic           mcu_nmi,
    input  logic           mcu_nmi_ack,
    input  logic           mcu_irq_req,
    output logic           mcu_irqmain,
    output logic           collision
);
    localparam int TW = $clog2(HALT_TO + 1);
    localparam int IW = $clog2(IRQ_LEN + 1);

    halt_st_t      st, st_nx;
    logic [TW-1:0] to_cnt;
    logic [IW-1:0] irq_cnt;
    logic          nmi_set_l;
    logic          main_rd_ok, mcu_rd_ok;
    logic          owner_main;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_data, ram_q;
    logic          ram_we;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st     <= RUN;
            to_cnt <= '0;
        end else begin
            st <= st_nx;
            if (st == RUN)       to_cnt <= '0;
            else if (st == HREQ) to_cnt <= to_cnt + 1'b1;
        end
    end

    always_comb begin
        st_nx     = st;
        mcu_ban   = 1'b0;
        mcu_haltn = 1'b1;
        case (st)
            RUN:    if (mcu_halt) st_nx = HREQ;
            HREQ: begin
                mcu_haltn = 1'b0;
                if (!mcu_halt)                                     st_nx = RUN;
                else if (mcu_bs || to_cnt == TW'(HALT_TO - 1))     st_nx = HALTED;
            end
            HALTED: begin
                mcu_ban   = 1'b1;
                mcu_haltn = 1'b0;
                if (!mcu_halt) st_nx = HREL;
            end
            HREL: begin
                mcu_haltn = 1'b0;
                st_nx     = RUN;
            end
            default: st_nx = RUN;
        endcase
    end

    // The bus belongs to the main CPU only once the halt is granted; otherwise the MCU owns it.
    assign owner_main = (st == HALTED);
    assign ram_addr   = owner_main ? bus.main_addr : bus.mcu_addr;
    assign ram_data   = owner_main ? bus.main_dout : bus.mcu_dout;
    assign ram_we     = owner_main ? (bus.main_cs & ~bus.main_rnw) : (bus.mcu_ram_cs & bus.mcu_wr);

    jtframe_ram #(.DW(8), .AW(AW)) u_ram (
        .clk  (clk),
        .addr (ram_addr),
        .data (ram_data),
        .we   (ram_we),
        .q    (ram_q)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            main_rd_ok <= 1'b0;
            mcu_rd_ok  <= 1'b0;
            collision  <= 1'b0;
            nmi_set_l  <= 1'b0;
            mcu_nmi    <= 1'b0;
            irq_cnt    <= '0;
        end else begin
            main_rd_ok <= owner_main & bus.main_cs;
            mcu_rd_ok  <= ~owner_main & bus.mcu_ram_cs;
            collision  <= collision | (bus.main_cs & ~owner_main);
            nmi_set_l  <= mcu_nmi_set;
            if (mcu_nmi_set && !nmi_set_l) mcu_nmi <= 1'b1;
            else if (mcu_nmi_ack)          mcu_nmi <= 1'b0;
            if (mcu_irq_req)                     irq_cnt <= IW'(IRQ_LEN);
            else if (cpu_cen && irq_cnt != '0)   irq_cnt <= irq_cnt - 1'b1;
        end
    end

    assign bus.main_din = main_rd_ok ? ram_q : IDLE_RD;
    assign bus.mcu_din  = mcu_rd_ok  ? ram_q : IDLE_RD;
    assign mcu_irqmain  = (irq_cnt != '0);
endmodule

// File: tb/tb_jtdd_mcu_com.sv
// tb/tb_jtdd_mcu_com.sv - directed self-checking bench for jtdd_mcu_com
module tb_jtdd_mcu_com;
    import jtdd_pkg::*;

    localparam int AW      = 9;
    localparam int IRQ_LEN = 4;
    localparam int HALT_TO = 64;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic cpu_cen = 1'b0;
    logic mcu_halt = 1'b0, mcu_nmi_set = 1'b0, mcu_bs = 1'b0;
    logic mcu_nmi_ack = 1'b0, mcu_irq_req = 1'b0;
    logic mcu_ban, mcu_haltn, mcu_nmi, mcu_irqmain, collision;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit cen_on = 1'b0;

    jtdd_mcu_com_if #(.AW(AW)) bus ();

    jtdd_mcu_com #(.AW(AW), .IRQ_LEN(IRQ_LEN), .HALT_TO(HALT_TO)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .cpu_cen     (cpu_cen),
        .bus         (bus.slave),
        .mcu_halt    (mcu_halt),
        .mcu_nmi_set (mcu_nmi_set),
        .mcu_ban     (mcu_ban),
        .mcu_haltn   (mcu_haltn),
        .mcu_bs      (mcu_bs),
        .mcu_nmi     (mcu_nmi),
        .mcu_nmi_ack (mcu_nmi_ack),
        .mcu_irq_req (mcu_irq_req),
        .mcu_irqmain (mcu_irqmain),
        .collision   (collision)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        cpu_cen = cen_on && (cyc % 4 == 3);
    endtask

    initial begin
        int n, g;
        bit re;

        bus.main_cs = 1'b0; bus.main_rnw = 1'b1; bus.main_addr = '0; bus.main_dout = '0;
        bus.mcu_ram_cs = 1'b0; bus.mcu_wr = 1'b0; bus.mcu_addr = '0; bus.mcu_dout = '0;

        tick(); tick();
        chk("rst_ban", mcu_ban, 0);
        chk("rst_haltn", mcu_haltn, 1);
        chk("rst_nmi", mcu_nmi, 0);
        chk("rst_irqmain", mcu_irqmain, 0);
        chk("rst_collision", collision, 0);
        chk("rst_main_din", bus.main_din, 8'hFF);
        chk("rst_mcu_din", bus.mcu_din, 8'hFF);
        rstn = 1'b1;
        tick();

        // halt handshake with boundary strobe already high
        mcu_bs = 1'b1; mcu_halt = 1'b1;
        tick();
        chk("hs_haltn_n1", mcu_haltn, 0);
        chk("hs_ban_n1", mcu_ban, 0);
        tick();
        chk("hs_ban_n2", mcu_ban, 1);
        bus.main_cs = 1'b1; bus.main_rnw = 1'b0; bus.main_addr = 9'h1FF; bus.main_dout = 8'h5A;
        tick();
        bus.main_rnw = 1'b1;
        tick();
        chk("halted_main_rd", bus.main_din, 8'h5A);
        bus.main_cs = 1'b0;
        bus.mcu_ram_cs = 1'b1; bus.mcu_wr = 1'b1; bus.mcu_addr = 9'h1FF; bus.mcu_dout = 8'h33;
        tick();
        chk("halted_mcu_rd", bus.mcu_din, 8'hFF);
        bus.mcu_ram_cs = 1'b0; bus.mcu_wr = 1'b0;
        mcu_halt = 1'b0;
        tick();
        chk("rel_ban", mcu_ban, 0);
        chk("rel_haltn_hold", mcu_haltn, 0);
        tick();
        chk("rel_haltn", mcu_haltn, 1);
        bus.mcu_ram_cs = 1'b1;
        tick();
        chk("mcu_rd_1ff", bus.mcu_din, 8'h5A);
        bus.mcu_ram_cs = 1'b0;
        chk("no_collision", collision, 0);

        // main access without the grant
        bus.main_cs = 1'b1; bus.main_rnw = 1'b1;
        tick();
        chk("run_main_rd", bus.main_din, 8'hFF);
        chk("collision_set", collision, 1);
        bus.main_rnw = 1'b0; bus.main_dout = 8'h77;
        tick();
        bus.main_cs = 1'b0; bus.main_rnw = 1'b1;
        bus.mcu_ram_cs = 1'b1;
        tick();
        chk("run_main_wr_dropped", bus.mcu_din, 8'h5A);
        bus.mcu_ram_cs = 1'b0;
        tick();
        chk("collision_sticky", collision, 1);

        // halt request withdrawn before the boundary
        mcu_bs = 1'b0; mcu_halt = 1'b1;
        tick();
        chk("abort_haltn0", mcu_haltn, 0);
        mcu_halt = 1'b0;
        tick();
        chk("abort_haltn1", mcu_haltn, 1);
        chk("abort_ban", mcu_ban, 0);

        // forced halt after timeout
        mcu_halt = 1'b1;
        n = 0;
        while (!mcu_ban && n < 200) begin
            tick();
            n++;
        end
        chk("halt_timeout", n, HALT_TO + 1);
        mcu_halt = 1'b0;
        tick(); tick();

        // NMI latch
        mcu_nmi_set = 1'b1;
        tick();
        chk("nmi_set", mcu_nmi, 1);
        tick(); tick();
        chk("nmi_hold", mcu_nmi, 1);
        mcu_nmi_set = 1'b0;
        tick();
        mcu_nmi_set = 1'b1; mcu_nmi_ack = 1'b1;
        tick();
        chk("nmi_set_wins", mcu_nmi, 1);
        mcu_nmi_set = 1'b0; mcu_nmi_ack = 1'b0;
        tick();
        mcu_nmi_ack = 1'b1;
        tick();
        chk("nmi_ack", mcu_nmi, 0);
        mcu_nmi_ack = 1'b0;

        // IRQ stretch
        cen_on = 1'b1;
        tick();
        g = 0;
        while (cpu_cen && g < 10) begin tick(); g++; end
        mcu_irq_req = 1'b1;
        tick();
        mcu_irq_req = 1'b0;
        chk("irq_rise", mcu_irqmain, 1);
        n = 0; g = 0;
        while (mcu_irqmain && g < 200) begin
            if (cpu_cen) n++;
            tick();
            g++;
        end
        chk("irq_len", n, IRQ_LEN);
        tick(); tick();
        g = 0;
        while (cpu_cen && g < 10) begin tick(); g++; end
        mcu_irq_req = 1'b1;
        tick();
        mcu_irq_req = 1'b0;
        n = 0; g = 0; re = 1'b0;
        while (mcu_irqmain && g < 200) begin
            if (cpu_cen) n++;
            if (n == 2 && !re && !cpu_cen) begin
                mcu_irq_req = 1'b1;
                re = 1'b1;
            end
            tick();
            mcu_irq_req = 1'b0;
            g++;
        end
        chk("irq_reload_len", n, 6);
        cen_on = 1'b0;
        tick();

        // main write completes while the halt drops in the same cycle
        mcu_bs = 1'b1; mcu_halt = 1'b1;
        tick(); tick();
        chk("halted_again", mcu_ban, 1);
        bus.main_cs = 1'b1; bus.main_rnw = 1'b0; bus.main_addr = 9'h010; bus.main_dout = 8'hA5;
        mcu_halt = 1'b0;
        tick();
        bus.main_cs = 1'b0; bus.main_rnw = 1'b1;
        mcu_halt = 1'b1;
        g = 0;
        while (!mcu_ban && g < 20) begin tick(); g++; end
        chk("halted_third", mcu_ban, 1);

        // asynchronous reset in HALTED
        rstn = 1'b0;
        #2;
        chk("arst_ban", mcu_ban, 0);
        chk("arst_haltn", mcu_haltn, 1);
        chk("arst_collision", collision, 0);
        mcu_halt = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        chk("post_rst_ban", mcu_ban, 0);
        chk("post_rst_haltn", mcu_haltn, 1);
        bus.mcu_ram_cs = 1'b1; bus.mcu_addr = 9'h010;
        tick();
        chk("ram_kept_010", bus.mcu_din, 8'hA5);
        bus.mcu_addr = 9'h1FF;
        tick();
        chk("ram_kept_1ff", bus.mcu_din, 8'h5A);
        bus.mcu_ram_cs = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
